// File: rtl/rv_csr_pkg.sv
// Shared CSR addresses, cause codes and enums for the M-mode trap controller.
// csr_apply computes the value a CSR instruction would write back.
package rv_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam logic [4:0] CAUSE_MSI    = 5'd3;
  localparam logic [4:0] CAUSE_MTI    = 5'd7;
  localparam logic [4:0] CAUSE_LOCAL0 = 5'd16;

  typedef enum logic [2:0] {
    OP_RW  = 3'b001,
    OP_RS  = 3'b010,
    OP_RC  = 3'b011,
    OP_RWI = 3'b101,
    OP_RSI = 3'b110,
    OP_RCI = 3'b111
  } csr_op_e;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } trap_state_e;

  function automatic logic [31:0] csr_apply(input logic [2:0]  op,
                                            input logic [31:0] old_val,
                                            input logic [31:0] wval);
    case (csr_op_e'(op))
      OP_RW, OP_RWI: return wval;
      OP_RS, OP_RSI: return old_val | wval;
      OP_RC, OP_RCI: return old_val & ~wval;
      default:       return old_val;
    endcase
  endfunction

endpackage

// File: rtl/rv_irq_prio_enc.sv
// Fixed-priority interrupt encoder: irq[0] highest, then MSI, then MTI.
module rv_irq_prio_enc
  import rv_csr_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0] irq_pend,
  input  logic               msi_pend,
  input  logic               mti_pend,
  output logic               any_pend,
  output logic [4:0]         cause
);

  // Lowest priority assigned first so higher-priority sources overwrite it.
  always_comb begin
    any_pend = (|irq_pend) | msi_pend | mti_pend;
    cause    = '0;
    if (mti_pend) cause = CAUSE_MTI;
    if (msi_pend) cause = CAUSE_MSI;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_pend[i]) cause = CAUSE_LOCAL0 + 5'(i);
    end
  end

endmodule

// File: rtl/rv_trap_ctrl.sv
// M-mode CSR file and trap/interrupt controller beside the rv32i MEM stage.
//   state | meaning
//   RUN   | traps and mret may redirect the pipeline
//   DRAIN | redirect in flight; traps/mret blocked until drain_cnt expires
module rv_trap_ctrl
  import rv_csr_pkg::*;
#(
  parameter int          NUM_IRQ     = 4,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
  parameter bit          VECTORED_EN = 1'b1,
  parameter int          DRAIN_CYC   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               csr_valid,
  input  logic [11:0]        csr_addr,
  input  logic [2:0]         csr_op,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  output logic               csr_illegal,
  input  logic               instr_valid,
  input  logic [31:0]        pc_mem,
  input  logic               mret_mem,
  input  logic               stall_pipl,
  input  logic               timer_int,
  input  logic               sw_int,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               trap_taken,
  output logic [31:0]        trap_pc,
  output logic               mret_exec,
  output logic [31:0]        mret_pc
);

  localparam int CW = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [CW-1:0] DRAIN_INIT = CW'(DRAIN_CYC - 1);

  trap_state_e   state;
  logic [CW-1:0] drain_cnt;
  logic          mst_mie, mst_mpie;
  logic [31:0]   mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [63:0]   mcycle_q, minstret_q;
  logic [31:0]   mip, mstatus_rd, csr_old, csr_new;
  logic          csr_hit, csr_we, irq_any, take;
  logic [4:0]    irq_cause;

  always_comb begin
    mip                 = '0;
    mip[3]              = sw_int;
    mip[7]              = timer_int;
    mip[16 +: NUM_IRQ]  = irq_i;
  end

  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mst_mpie, 3'b0, mst_mie, 3'b0};

  rv_irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .irq_pend (irq_i & mie_q[16 +: NUM_IRQ]),
    .msi_pend (sw_int & mie_q[3]),
    .mti_pend (timer_int & mie_q[7]),
    .any_pend (irq_any),
    .cause    (irq_cause)
  );

  always_comb begin
    csr_hit = 1'b1;
    csr_old = '0;
    case (csr_addr)
      CSR_MSTATUS:   csr_old = mstatus_rd;
      CSR_MIE:       csr_old = mie_q;
      CSR_MTVEC:     csr_old = mtvec_q;
      CSR_MSCRATCH:  csr_old = mscratch_q;
      CSR_MEPC:      csr_old = mepc_q;
      CSR_MCAUSE:    csr_old = mcause_q;
      CSR_MIP:       csr_old = mip;
      CSR_MCYCLE:    csr_old = mcycle_q[31:0];
      CSR_MCYCLEH:   csr_old = mcycle_q[63:32];
      CSR_MINSTRET:  csr_old = minstret_q[31:0];
      CSR_MINSTRETH: csr_old = minstret_q[63:32];
      default:       csr_hit = 1'b0;
    endcase
  end

  assign csr_new     = csr_apply(csr_op, csr_old, csr_wdata);
  assign csr_rdata   = csr_valid ? csr_old : '0;
  assign csr_illegal = csr_valid & ~csr_hit;

  assign take = (state == RUN) & mst_mie & irq_any & instr_valid & ~stall_pipl;

  // Set/clear forms (op[1]=1) with a zero operand must not write.
  assign csr_we = csr_valid & csr_hit & (csr_op[1:0] != 2'b00) & ~stall_pipl & ~take
                & ~(csr_op[1] & (csr_wdata == '0));

  assign trap_taken = take;
  assign trap_pc    = take ? ({mtvec_q[31:2], 2'b00}
                              + ((mtvec_q[1:0] == 2'b01) ? {25'b0, irq_cause, 2'b00} : 32'd0))
                           : '0;
  assign mret_exec  = (state == RUN) & mret_mem & instr_valid & ~stall_pipl & ~take;
  assign mret_pc    = mepc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      drain_cnt  <= '0;
      mst_mie    <= 1'b0;
      mst_mpie   <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q <= mcycle_q + 64'd1;
      if (instr_valid & ~stall_pipl & ~take) minstret_q <= minstret_q + 64'd1;

      if (csr_we) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            mst_mie  <= csr_new[3];
            mst_mpie <= csr_new[7];
          end
          CSR_MIE:       mie_q      <= csr_new;
          CSR_MTVEC:     mtvec_q    <= {csr_new[31:2], 1'b0, csr_new[0] & VECTORED_EN};
          CSR_MSCRATCH:  mscratch_q <= csr_new;
          CSR_MEPC:      mepc_q     <= {csr_new[31:2], 2'b00};
          CSR_MCAUSE:    mcause_q   <= csr_new;
          CSR_MCYCLE:    mcycle_q   <= {mcycle_q[63:32], csr_new};
          CSR_MCYCLEH:   mcycle_q   <= {csr_new, mcycle_q[31:0]};
          CSR_MINSTRET:  minstret_q <= {minstret_q[63:32], csr_new};
          CSR_MINSTRETH: minstret_q <= {csr_new, minstret_q[31:0]};
          default: ;
        endcase
      end

      if (take) begin
        mepc_q   <= pc_mem;
        mcause_q <= {1'b1, 26'b0, irq_cause};
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
      end else if (mret_exec) begin
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
      end

      case (state)
        RUN: begin
          if (take | mret_exec) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_INIT;
          end
        end
        DRAIN: begin
          if (~stall_pipl) begin
            if (drain_cnt == '0) state <= RUN;
            else drain_cnt <= drain_cnt - CW'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_trap_ctrl.sv
// Scoreboard bench for rv_trap_ctrl: expectations queued at drive time, popped at sample.
module tb_rv_trap_ctrl;
  import rv_csr_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        csr_valid;
  logic [11:0] csr_addr;
  logic [2:0]  csr_op;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        instr_valid;
  logic [31:0] pc_mem;
  logic        mret_mem;
  logic        stall_pipl;
  logic        timer_int;
  logic        sw_int;
  logic [3:0]  irq_i;
  logic        trap_taken;
  logic [31:0] trap_pc;
  logic        mret_exec;
  logic [31:0] mret_pc;

  always #5 clk = ~clk;

  rv_trap_ctrl #(
    .NUM_IRQ(4), .MTVEC_RESET(32'h0000_0100), .VECTORED_EN(1'b1), .DRAIN_CYC(3)
  ) dut (
    .clk(clk), .reset(reset),
    .csr_valid(csr_valid), .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .instr_valid(instr_valid), .pc_mem(pc_mem), .mret_mem(mret_mem), .stall_pipl(stall_pipl),
    .timer_int(timer_int), .sw_int(sw_int), .irq_i(irq_i),
    .trap_taken(trap_taken), .trap_pc(trap_pc), .mret_exec(mret_exec), .mret_pc(mret_pc)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] act);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_underflow: got 0x%08h with no expectation queued", act);
    end else begin
      e = sb_q.pop_front();
      check_eq(e.tag, act, e.val);
    end
  endtask

  task automatic obs(input string tag, input logic [31:0] act, input logic [31:0] exp);
    sb_push(tag, exp);
    sb_pop(act);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] addr, input logic [31:0] val);
    csr_valid = 1'b1; csr_addr = addr; csr_op = 3'b001; csr_wdata = val;
    step();
    csr_valid = 1'b0;
  endtask

  task automatic csr_cycle(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic exp_ill, input string tag);
    sb_push({tag, "_rdata"}, exp_rd);
    sb_push({tag, "_illegal"}, 32'(exp_ill));
    csr_valid = 1'b1; csr_addr = addr; csr_op = op; csr_wdata = wd;
    #1;
    sb_pop(csr_rdata);
    sb_pop(32'(csr_illegal));
    step();
    csr_valid = 1'b0;
  endtask

  task automatic csr_rd(input logic [11:0] addr, input logic [31:0] exp, input string tag);
    csr_cycle(3'b010, addr, 32'd0, exp, 1'b0, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; csr_valid = 1'b0; csr_addr = '0; csr_op = '0; csr_wdata = '0;
    instr_valid = 1'b0; pc_mem = '0; mret_mem = 1'b0; stall_pipl = 1'b0;
    timer_int = 1'b0; sw_int = 1'b0; irq_i = '0;
    repeat (2) @(posedge clk);
    #1;
    obs("rst_trap_taken", 32'(trap_taken), 32'd0);
    obs("rst_trap_pc", trap_pc, 32'd0);
    obs("rst_mret_exec", 32'(mret_exec), 32'd0);
    obs("rst_mret_pc", mret_pc, 32'd0);
    reset = 1'b0;
    csr_rd(CSR_MSTATUS, 32'h0000_1800, "rst_mstatus");
    csr_rd(CSR_MTVEC, 32'h0000_0100, "rst_mtvec");
    csr_rd(CSR_MIE, 32'h0, "rst_mie");

    // 1: direct-mode timer trap
    csr_wr(CSR_MTVEC, 32'h200);
    csr_wr(CSR_MIE, 32'h80);
    csr_wr(CSR_MSTATUS, 32'h8);
    timer_int = 1'b1; pc_mem = 32'h40; instr_valid = 1'b1;
    #1;
    obs("t1_taken", 32'(trap_taken), 32'd1);
    obs("t1_trap_pc", trap_pc, 32'h200);
    step();
    instr_valid = 1'b0; timer_int = 1'b0;
    #1;
    obs("t1_one_cycle", 32'(trap_taken), 32'd0);
    csr_rd(CSR_MEPC, 32'h40, "t1_mepc");
    csr_rd(CSR_MCAUSE, 32'h8000_0007, "t1_mcause");
    csr_rd(CSR_MSTATUS, 32'h0000_1880, "t1_mstatus");

    // 2: vectored, platform irq beats software irq
    csr_wr(CSR_MTVEC, 32'h201);
    csr_wr(CSR_MIE, (32'd1 << 18) | (32'd1 << 3));
    csr_wr(CSR_MSTATUS, 32'h8);
    sw_int = 1'b1; irq_i = 4'b0100; pc_mem = 32'h80; instr_valid = 1'b1;
    #1;
    obs("t2_taken", 32'(trap_taken), 32'd1);
    obs("t2_trap_pc", trap_pc, 32'h248);
    step();
    instr_valid = 1'b0; sw_int = 1'b0; irq_i = '0;
    csr_rd(CSR_MCAUSE, 32'h8000_0012, "t2_mcause");
    csr_rd(CSR_MEPC, 32'h80, "t2_mepc");

    // 3: mret then drain window blocks a pending interrupt for 3 cycles
    csr_wr(CSR_MEPC, 32'h44);
    csr_wr(CSR_MSTATUS, 32'h80);
    step();
    sw_int = 1'b1; mret_mem = 1'b1; instr_valid = 1'b1; pc_mem = 32'h90;
    #1;
    obs("t3_mret_exec", 32'(mret_exec), 32'd1);
    obs("t3_mret_pc", mret_pc, 32'h44);
    obs("t3_no_trap", 32'(trap_taken), 32'd0);
    step();
    mret_mem = 1'b0;
    csr_valid = 1'b1; csr_addr = CSR_MSTATUS; csr_op = 3'b010; csr_wdata = 32'd0;
    #1;
    obs("t3_mstatus", csr_rdata, 32'h0000_1888);
    obs("t3_block_c1", 32'(trap_taken), 32'd0);
    step();
    csr_valid = 1'b0;
    for (int k = 2; k <= 3; k++) begin
      #1;
      obs($sformatf("t3_block_c%0d", k), 32'(trap_taken), 32'd0);
      step();
    end
    #1;
    obs("t3_take_c4", 32'(trap_taken), 32'd1);
    obs("t3_trap_pc", trap_pc, 32'h20C);
    step();
    instr_valid = 1'b0; sw_int = 1'b0;

    // 4: set/clear semantics, WARL fields, illegal address
    csr_wr(CSR_MSTATUS, 32'h0);
    csr_wr(CSR_MSCRATCH, 32'h1234_5678);
    csr_cycle(3'b010, CSR_MSCRATCH, 32'd0, 32'h1234_5678, 1'b0, "t4_rs_zero");
    csr_rd(CSR_MSCRATCH, 32'h1234_5678, "t4_scratch_kept");
    csr_wr(CSR_MIE, 32'hFF);
    csr_cycle(3'b011, CSR_MIE, 32'h80, 32'hFF, 1'b0, "t4_rc_mie");
    csr_rd(CSR_MIE, 32'h7F, "t4_mie_cleared");
    csr_cycle(3'b001, 12'h7C0, 32'hABCD, 32'd0, 1'b1, "t4_illegal");
    csr_wr(CSR_MTVEC, 32'hFFFF_FFFF);
    csr_rd(CSR_MTVEC, 32'hFFFF_FFFD, "t4_mtvec_warl");
    csr_wr(CSR_MEPC, 32'h103);
    csr_rd(CSR_MEPC, 32'h100, "t4_mepc_align");
    csr_cycle(3'b101, CSR_MSCRATCH, 32'h1F, 32'h1234_5678, 1'b0, "t4_rwi");
    csr_rd(CSR_MSCRATCH, 32'h1F, "t4_rwi_written");

    // 5: 64-bit counter carry, minstret gating
    csr_wr(CSR_MCYCLE, 32'hFFFF_FFFF);
    step();
    csr_rd(CSR_MCYCLE, 32'h0, "t5_mcycle_lo");
    csr_rd(CSR_MCYCLEH, 32'h1, "t5_mcycle_hi");
    csr_wr(CSR_MTVEC, 32'h300);
    csr_wr(CSR_MIE, 32'h80);
    csr_wr(CSR_MSTATUS, 32'h8);
    csr_wr(CSR_MINSTRET, 32'h0);
    instr_valid = 1'b1;
    repeat (3) step();
    stall_pipl = 1'b1;
    repeat (2) step();
    stall_pipl = 1'b0; timer_int = 1'b1;
    #1;
    obs("t5_trap_taken", 32'(trap_taken), 32'd1);
    obs("t5_trap_pc", trap_pc, 32'h300);
    step();
    instr_valid = 1'b0; timer_int = 1'b0;
    csr_rd(CSR_MINSTRET, 32'd3, "t5_minstret");
    csr_rd(CSR_MINSTRETH, 32'd0, "t5_minstreth");

    // 6: trap beats mret; reset during drain
    csr_wr(CSR_MSTATUS, 32'h8);
    timer_int = 1'b1; mret_mem = 1'b1; instr_valid = 1'b1; pc_mem = 32'h500;
    #1;
    obs("t6_trap_wins", 32'(trap_taken), 32'd1);
    obs("t6_no_mret", 32'(mret_exec), 32'd0);
    step();
    mret_mem = 1'b0; instr_valid = 1'b0; timer_int = 1'b0;
    csr_rd(CSR_MEPC, 32'h500, "t6_mepc");
    csr_rd(CSR_MSTATUS, 32'h0000_1880, "t6_mstatus");
    reset = 1'b1;
    step();
    reset = 1'b0;
    mret_mem = 1'b1; instr_valid = 1'b1;
    #1;
    obs("t6_run_after_rst", 32'(mret_exec), 32'd1);
    obs("t6_mret_pc_rst", mret_pc, 32'd0);
    mret_mem = 1'b0; instr_valid = 1'b0;
    csr_rd(CSR_MSTATUS, 32'h0000_1800, "t6_rst_mstatus");
    csr_rd(CSR_MIE, 32'h0, "t6_rst_mie");
    csr_rd(CSR_MTVEC, 32'h100, "t6_rst_mtvec");
    csr_rd(CSR_MEPC, 32'h0, "t6_rst_mepc");
    csr_rd(CSR_MCAUSE, 32'h0, "t6_rst_mcause");
    csr_rd(CSR_MSCRATCH, 32'h0, "t6_rst_mscratch");
    csr_rd(CSR_MCYCLEH, 32'h0, "t6_rst_mcycleh");
    csr_rd(CSR_MINSTRET, 32'h0, "t6_rst_minstret");

    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d expectations never observed", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
